// File: rtl/awsf1_sda_pkg.sv
// Shared types for the SDA AXI-Lite initiator: FSM states, AXI resp codes,
// command/response bundles. AWSF1_SDA_AXIL_TIMEOUT_EN adds the DRAIN state.
package awsf1_sda_pkg;

   localparam int SDA_AW = 32;
   localparam int SDA_DW = 32;

`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WR_B, S_RD_AR, S_RD_R, S_RSP, S_DRAIN
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WR_B, S_RD_AR, S_RD_R, S_RSP
   } state_t;
`endif

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef struct packed {
      logic              write;
      logic [SDA_AW-1:0] addr;
      logic [SDA_DW-1:0] wdata;
      logic [SDA_DW/8-1:0] wstrb;
   } sda_cmd_t;

   typedef struct packed {
      logic              write;
      logic [SDA_DW-1:0] rdata;
      logic [1:0]        resp;
   } sda_rsp_t;

endpackage

// File: rtl/awsf1_sda_axil_initiator.sv
// Single-outstanding AXI-Lite master for the SDA BAR4 register bus.
// Optional response watchdog: define AWSF1_SDA_AXIL_TIMEOUT_EN.
module awsf1_sda_axil_initiator
   import awsf1_sda_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_main_a0,
   input  logic                    rst_main,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    sda_cl_awvalid,
   output logic [ADDR_WIDTH-1:0]   sda_cl_awaddr,
   input  logic                    cl_sda_awready,
   output logic                    sda_cl_wvalid,
   output logic [DATA_WIDTH-1:0]   sda_cl_wdata,
   output logic [DATA_WIDTH/8-1:0] sda_cl_wstrb,
   input  logic                    cl_sda_wready,
   input  logic                    cl_sda_bvalid,
   input  logic [1:0]              cl_sda_bresp,
   output logic                    sda_cl_bready,
   output logic                    sda_cl_arvalid,
   output logic [ADDR_WIDTH-1:0]   sda_cl_araddr,
   input  logic                    cl_sda_arready,
   input  logic                    cl_sda_rvalid,
   input  logic [DATA_WIDTH-1:0]   cl_sda_rdata,
   input  logic [1:0]              cl_sda_rresp,
   output logic                    sda_cl_rready
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << LSB;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t state, state_n;

   logic                    cmd_ready_n, rsp_valid_n, rsp_write_n;
   logic [DATA_WIDTH-1:0]   rsp_rdata_n;
   logic [1:0]              rsp_resp_n;
   logic                    awvalid_n, wvalid_n, arvalid_n;
   logic                    bready_n, rready_n;
   logic [ADDR_WIDTH-1:0]   awaddr_n, araddr_n;
   logic [DATA_WIDTH-1:0]   wdata_n;
   logic [STRB_W-1:0]       wstrb_n;
   logic                    aw_done, w_done;

`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
   localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] cnt, cnt_n;
   logic        drain, drain_n, expired, late_beat;
`endif

   always_comb begin
      state_n     = state;
      awvalid_n   = sda_cl_awvalid;
      wvalid_n    = sda_cl_wvalid;
      arvalid_n   = sda_cl_arvalid;
      awaddr_n    = sda_cl_awaddr;
      araddr_n    = sda_cl_araddr;
      wdata_n     = sda_cl_wdata;
      wstrb_n     = sda_cl_wstrb;
      rsp_valid_n = rsp_valid;
      rsp_write_n = rsp_write;
      rsp_rdata_n = rsp_rdata;
      rsp_resp_n  = rsp_resp;
      aw_done     = !sda_cl_awvalid || cl_sda_awready;
      w_done      = !sda_cl_wvalid || cl_sda_wready;
`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
      drain_n   = drain;
      expired   = (cnt == TO_LIM);
      late_beat = (sda_cl_bready && cl_sda_bvalid) ||
                  (sda_cl_rready && cl_sda_rvalid);
`endif
      unique case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               rsp_write_n = cmd_write;
               if (cmd_write) begin
                  state_n   = S_WR;
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  awaddr_n  = cmd_addr & ADDR_MASK;
                  wdata_n   = cmd_wdata;
                  wstrb_n   = cmd_wstrb;
               end else begin
                  state_n   = S_RD_AR;
                  arvalid_n = 1'b1;
                  araddr_n  = cmd_addr & ADDR_MASK;
               end
            end
         end
         S_WR: begin
            awvalid_n = sda_cl_awvalid && !cl_sda_awready;
            wvalid_n  = sda_cl_wvalid && !cl_sda_wready;
            if (aw_done && w_done) begin
               state_n = S_WR_B;
            end
`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
            else if (expired) begin
               awvalid_n   = 1'b0;
               wvalid_n    = 1'b0;
               state_n     = S_RSP;
               rsp_valid_n = 1'b1;
               rsp_resp_n  = RESP_DECERR;
               rsp_rdata_n = DATA_WIDTH'(TIMEOUT_RDATA);
               drain_n     = 1'b1;
            end
`endif
         end
         S_WR_B: begin
            if (sda_cl_bready && cl_sda_bvalid) begin
               state_n     = S_RSP;
               rsp_valid_n = 1'b1;
               rsp_resp_n  = cl_sda_bresp;
               rsp_rdata_n = '0;
            end
`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
            else if (expired) begin
               state_n     = S_RSP;
               rsp_valid_n = 1'b1;
               rsp_resp_n  = RESP_DECERR;
               rsp_rdata_n = DATA_WIDTH'(TIMEOUT_RDATA);
               drain_n     = 1'b1;
            end
`endif
         end
         S_RD_AR: begin
            if (cl_sda_arready) begin
               arvalid_n = 1'b0;
               state_n   = S_RD_R;
            end
         end
         S_RD_R: begin
            if (sda_cl_rready && cl_sda_rvalid) begin
               state_n     = S_RSP;
               rsp_valid_n = 1'b1;
               rsp_resp_n  = cl_sda_rresp;
               rsp_rdata_n = cl_sda_rdata;
            end
`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
            else if (expired) begin
               state_n     = S_RSP;
               rsp_valid_n = 1'b1;
               rsp_resp_n  = RESP_DECERR;
               rsp_rdata_n = DATA_WIDTH'(TIMEOUT_RDATA);
               drain_n     = 1'b1;
            end
`endif
         end
         S_RSP: begin
`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
            // A late beat while the DECERR is pending counts as drained
            if (drain && late_beat) drain_n = 1'b0;
`endif
            if (rsp_ready) begin
               rsp_valid_n = 1'b0;
               state_n     = S_IDLE;
`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
               if (drain_n) state_n = S_DRAIN;
`endif
            end
         end
`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
         S_DRAIN: begin
            if (late_beat || expired) begin
               drain_n = 1'b0;
               state_n = S_IDLE;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
      cmd_ready_n = (state_n == S_IDLE);
      bready_n    = (state_n == S_WR_B);
      rready_n    = (state_n == S_RD_R);
`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
      if (drain_n && (state_n == S_RSP || state_n == S_DRAIN)) begin
         bready_n = rsp_write;
         rready_n = !rsp_write;
      end
      cnt_n = (state_n != state) ? '0 : cnt + 32'd1;
`endif
   end

   always_ff @(posedge clk_main_a0 or posedge rst_main) begin
      if (rst_main) begin
         state          <= S_IDLE;
         cmd_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_write      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_resp       <= RESP_OKAY;
         sda_cl_awvalid <= 1'b0;
         sda_cl_awaddr  <= '0;
         sda_cl_wvalid  <= 1'b0;
         sda_cl_wdata   <= '0;
         sda_cl_wstrb   <= '0;
         sda_cl_bready  <= 1'b0;
         sda_cl_arvalid <= 1'b0;
         sda_cl_araddr  <= '0;
         sda_cl_rready  <= 1'b0;
      end else begin
         state          <= state_n;
         cmd_ready      <= cmd_ready_n;
         rsp_valid      <= rsp_valid_n;
         rsp_write      <= rsp_write_n;
         rsp_rdata      <= rsp_rdata_n;
         rsp_resp       <= rsp_resp_n;
         sda_cl_awvalid <= awvalid_n;
         sda_cl_awaddr  <= awaddr_n;
         sda_cl_wvalid  <= wvalid_n;
         sda_cl_wdata   <= wdata_n;
         sda_cl_wstrb   <= wstrb_n;
         sda_cl_bready  <= bready_n;
         sda_cl_arvalid <= arvalid_n;
         sda_cl_araddr  <= araddr_n;
         sda_cl_rready  <= rready_n;
      end
   end

`ifdef AWSF1_SDA_AXIL_TIMEOUT_EN
   always_ff @(posedge clk_main_a0 or posedge rst_main) begin
      if (rst_main) begin
         cnt   <= '0;
         drain <= 1'b0;
      end else begin
         cnt   <= cnt_n;
         drain <= drain_n;
      end
   end
`endif

endmodule
